// File: rtl/alu_div_sequencer.sv
// Request/response front end for the non-restoring divider: accepts signed 8-bit
// divide requests, drives the divider, holds the result until the consumer takes it.
module alu_div_sequencer #(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic signed [7:0]        req_a,
    input  logic signed [7:0]        req_b,
    input  logic        [TAG_W-1:0]  req_tag,
    output logic                     div_start,
    output logic signed [7:0]        div_a,
    output logic signed [7:0]        div_b,
    input  logic signed [15:0]       div_quotient,
    input  logic signed [15:0]       div_remainder,
    input  logic                     div_done,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic signed [15:0]       resp_quotient,
    output logic signed [15:0]       resp_remainder,
    output logic        [TAG_W-1:0]  resp_tag,
    output logic        [1:0]        resp_err,
    output logic        [15:0]       op_count
);

    localparam int          CNT_W   = $clog2(TIMEOUT);
    localparam logic [1:0]  ERR_OK  = 2'b00;
    localparam logic [1:0]  ERR_DZ  = 2'b01;
    localparam logic [1:0]  ERR_TMO = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               accept, done_hit, tmo_hit, resp_fire;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // done is only trusted in WAIT, so a level-held done from the previous op is ignored
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        div_start  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        done_hit   = 1'b0;
        tmo_hit    = 1'b0;
        resp_fire  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = (req_b == 8'sd0) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                div_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (div_done) begin
                    done_hit  = 1'b1;
                    state_nxt = RESP;
                end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    resp_fire = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_a          <= '0;
            div_b          <= '0;
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_tag       <= '0;
            resp_err       <= ERR_OK;
            op_count       <= '0;
            tmo_cnt        <= '0;
        end else begin
            if (accept) begin
                div_a    <= req_a;
                div_b    <= req_b;
                resp_tag <= req_tag;
                if (req_b == 8'sd0) begin
                    resp_quotient  <= '0;
                    resp_remainder <= '0;
                    resp_err       <= ERR_DZ;
                end
            end
            if (div_start)
                tmo_cnt <= '0;
            else if (state == WAIT)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (done_hit) begin
                resp_quotient  <= div_quotient;
                resp_remainder <= div_remainder;
                resp_err       <= ERR_OK;
            end else if (tmo_hit) begin
                resp_quotient  <= '0;
                resp_remainder <= '0;
                resp_err       <= ERR_TMO;
            end
            if (resp_fire)
                op_count <= sat_inc(op_count);
        end
    end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Directed bench for alu_div_sequencer with a behavioural divider stub
// (fixed latency, level-held done, optional hang).
module tb_alu_div_sequencer;

    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 64;
    localparam int DIV_LAT = 10;
    localparam int D       = DIV_LAT + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_a, req_b;
    logic [3:0]  req_tag;
    logic        div_start;
    logic [7:0]  div_a, div_b;
    logic [15:0] div_quotient  = '0;
    logic [15:0] div_remainder = '0;
    logic        div_done      = 1'b0;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_quotient, resp_remainder;
    logic [3:0]  resp_tag;
    logic [1:0]  resp_err;
    logic [15:0] op_count;

    alu_div_sequencer #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
        .resp_tag(resp_tag), .resp_err(resp_err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Divider stub: done clears on the start edge, rises DIV_LAT+1 cycles after start
    logic [4:0]         stub_cnt = '0;
    logic               hang     = 1'b0;
    logic signed [15:0] sa, sb;
    assign sa = {{8{div_a[7]}}, div_a};
    assign sb = {{8{div_b[7]}}, div_b};

    always @(posedge clk) begin
        if (div_start) begin
            stub_cnt      <= 5'(DIV_LAT);
            div_done      <= 1'b0;
            div_quotient  <= sa / sb;
            div_remainder <= sa % sb;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1'b1;
            if (stub_cnt == 1 && !hang) div_done <= 1'b1;
        end
    end

    int          n_start = 0, n_acc = 0, n_resp = 0;
    logic [15:0] mq[$], mr[$];
    logic [1:0]  me[$];
    logic [3:0]  mt[$];

    always @(posedge clk) begin
        if (div_start) n_start <= n_start + 1;
        if (req_valid && req_ready) n_acc <= n_acc + 1;
        if (resp_valid && resp_ready) begin
            n_resp <= n_resp + 1;
            mq.push_back(resp_quotient);
            mr.push_back(resp_remainder);
            me.push_back(resp_err);
            mt.push_back(resp_tag);
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, return cycles from the accept edge to resp_valid
    task automatic xact(input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag,
                        output int lat);
        int w;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        w = 0;
        while (!req_ready && w < 200) begin
            tick();
            w++;
        end
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 300) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, s0, r0, a0, nr_rst, w;
        bit ok;
        logic [7:0] va[3];
        logic [7:0] vb[3];

        reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_tag = '0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_div_start", div_start, 0);
        check("rst_op_count", op_count, 0);
        check("rst_div_a", div_a, 0);
        check("rst_resp_err", resp_err, 0);
        reset = 1'b0;
        tick();

        // 25 / 5
        resp_ready = 1'b1;
        s0 = n_start;
        xact(8'd25, 8'd5, 4'd3, lat);
        check("t1_lat", lat, 2 + D);
        check("t1_q", resp_quotient, 16'd5);
        check("t1_r", resp_remainder, 16'd0);
        check("t1_tag", resp_tag, 4'd3);
        check("t1_err", resp_err, 2'b00);
        check("t1_div_a", div_a, 8'd25);
        tick();
        check("t1_starts", n_start - s0, 1);
        check("t1_op_count", op_count, 1);
        check("t1_req_ready", req_ready, 1);

        // 5 / 0
        s0 = n_start;
        xact(8'd5, 8'd0, 4'd5, lat);
        check("dz_lat", lat, 1);
        check("dz_q", resp_quotient, 16'd0);
        check("dz_r", resp_remainder, 16'd0);
        check("dz_err", resp_err, 2'b01);
        check("dz_tag", resp_tag, 4'd5);
        tick();
        check("dz_starts", n_start - s0, 0);
        check("dz_op_count", op_count, 2);

        // 127 / 3 with consumer stalled for 10 cycles and a competing request pending
        resp_ready = 1'b0;
        xact(8'd127, 8'd3, 4'd6, lat);
        check("hold_lat", lat, 2 + D);
        req_valid = 1'b1; req_a = 8'd1; req_b = 8'd1; req_tag = 4'd15;
        a0 = n_acc;
        ok = 1'b1;
        repeat (10) begin
            if (!(resp_valid && resp_quotient == 16'd42 && resp_remainder == 16'd1 &&
                  resp_tag == 4'd6 && resp_err == 2'b00 && !req_ready)) ok = 1'b0;
            tick();
        end
        check("hold_stable", ok, 1);
        check("hold_no_accept", n_acc - a0, 0);
        check("hold_op_count", op_count, 2);
        check("hold_div_a", div_a, 8'd127);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        check("hold_release_cnt", op_count, 3);
        check("hold_release_valid", resp_valid, 0);

        // Hung divider, then a normal op
        hang = 1'b1;
        xact(8'd100, 8'd3, 4'd7, lat);
        check("tmo_lat", lat, TIMEOUT + 2);
        check("tmo_err", resp_err, 2'b10);
        check("tmo_q", resp_quotient, 16'd0);
        check("tmo_r", resp_remainder, 16'd0);
        tick();
        hang = 1'b0;
        xact(8'd54, 8'd7, 4'd8, lat);
        check("after_tmo_lat", lat, 2 + D);
        check("after_tmo_q", resp_quotient, 16'd7);
        check("after_tmo_r", resp_remainder, 16'd5);
        check("after_tmo_err", resp_err, 2'b00);
        tick();
        check("after_tmo_cnt", op_count, 5);

        // Asynchronous reset while waiting on -128 / 7
        req_valid = 1'b1; req_a = 8'h80; req_b = 8'd7; req_tag = 4'd9;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_req_ready", req_ready, 1);
        check("arst_div_a", div_a, 0);
        check("arst_div_b", div_b, 0);
        check("arst_op_count", op_count, 0);
        check("arst_resp_valid", resp_valid, 0);
        check("arst_div_start", div_start, 0);
        tick();
        reset = 1'b0;
        nr_rst = n_resp;
        repeat (20) tick();
        check("arst_no_resp", n_resp - nr_rst, 0);
        xact(8'hE7, 8'hFB, 4'd10, lat);
        check("neg_lat", lat, 2 + D);
        check("neg_q", resp_quotient, 16'd5);
        check("neg_r", resp_remainder, 16'd0);
        check("neg_err", resp_err, 2'b00);
        tick();
        check("neg_op_count", op_count, 1);

        // Back-to-back with req_valid held high
        va[0] = 8'd9;  vb[0] = 8'd2;
        va[1] = 8'hF7; vb[1] = 8'd2;
        va[2] = 8'd7;  vb[2] = 8'd0;
        mq.delete(); mr.delete(); me.delete(); mt.delete();
        r0 = n_resp;
        a0 = n_acc;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_a = va[i]; req_b = vb[i]; req_tag = 4'(i + 1);
            w = 0;
            while (!req_ready && w < 200) begin
                tick();
                w++;
            end
            tick();
        end
        req_valid = 1'b0;
        w = 0;
        while (n_resp - r0 < 3 && w < 200) begin
            tick();
            w++;
        end
        tick();
        check("b2b_resps", n_resp - r0, 3);
        check("b2b_accepts", n_acc - a0, 3);
        check("b2b_op_count", op_count, 4);
        check("b2b_count_vs_resps", op_count, n_resp - nr_rst);
        if (mq.size() == 3) begin
            check("b2b0_q", mq[0], 16'd4);
            check("b2b0_r", mr[0], 16'd1);
            check("b2b0_tag", mt[0], 4'd1);
            check("b2b1_q", mq[1], 16'hFFFC);
            check("b2b1_r", mr[1], 16'hFFFF);
            check("b2b1_tag", mt[1], 4'd2);
            check("b2b2_err", me[2], 2'b01);
            check("b2b2_q", mq[2], 16'd0);
            check("b2b2_tag", mt[2], 4'd3);
        end else begin
            check("b2b_queue_size", mq.size(), 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_div_sequencer.md
Name: alu_div_sequencer

Overview:
- Request/response front end that sits directly upstream of the non-restoring divider (`non_rest_div_mihai`) in the ALU datapath.
- Accepts signed 8-bit divide requests over a valid/ready handshake and pulses the divider's `start`.
- Waits for `done`, then holds the quotient/remainder in a response register until the consumer accepts it.
- Handles divide-by-zero locally, guards against a hung divider with a timeout, and keeps a completed-operation counter.

Parameters:
- TAG_W, 4, width of the opaque request tag echoed on the response.
- TIMEOUT, 64, max cycles spent in WAIT before the operation is aborted with a timeout error (must be ≥ 20).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  8  signed dividend.
- req_b  in  8  signed divisor.
- req_tag  in  TAG_W  request tag.
- div_start  out  1  one-cycle start pulse to the divider.
- div_a  out  8  dividend to the divider, held stable from ISSUE until leaving WAIT.
- div_b  out  8  divisor to the divider, held stable from ISSUE until leaving WAIT.
- div_quotient  in  16  signed quotient from the divider.
- div_remainder  in  16  signed remainder from the divider.
- div_done  in  1  divider completion.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_quotient  out  16  registered quotient.
- resp_remainder  out  16  registered remainder.
- resp_tag  out  TAG_W  tag of the answered request.
- resp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout.
- op_count  out  16  completed responses, saturating at 16'hFFFF.

Behaviour:
- Reset (asynchronous, any state, including mid-operation) forces:
  - state IDLE;
  - req_ready=1, div_start=0, resp_valid=0;
  - div_a=0, div_b=0, resp_quotient=0, resp_remainder=0, resp_tag=0, resp_err=00, op_count=0;
  - timeout counter=0.
  - An operation in flight is dropped with no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1.
  - On req_valid&req_ready, capture a, b, tag.
  - If req_b==0, go directly to RESP with quotient=0, remainder=0, err=01; the divider is never started.
  - Otherwise, go to ISSUE.
- ISSUE: lasts exactly one cycle with div_start=1; next state is WAIT and the timeout counter clears.
- WAIT: div_start=0; the counter increments each cycle.
  - On div_done=1, register div_quotient/div_remainder unmodified, set err=00, go to RESP.
  - If the counter reaches TIMEOUT-1 without div_done, go to RESP with quotient=0, remainder=0, err=10.
  - If div_done and the timeout condition coincide, div_done wins (err=00).
- RESP: resp_valid=1; resp_* fields are stable while resp_valid=1 and resp_ready=0.
  - On resp_ready=1, return to IDLE and increment op_count (saturating).
  - No bypass: a new request is accepted only from IDLE, so the earliest accept is the cycle after the response handshake.
- req_ready=0 in ISSUE, WAIT and RESP; req_valid there is ignored and the request must be held by the producer.
- Divider contract: div_done is low on the first WAIT cycle (the divider clears done on the edge sampling start). The sequencer samples div_done only in WAIT, so a level-held done left over from a previous op is never mistaken for completion.
- Latency:
  - nonzero divisor: req handshake → resp_valid is 2 + D cycles, where D = cycles from start to done;
  - zero divisor: resp_valid is asserted 1 cycle after the accept.
- div_a/div_b are updated only on request accept.

Test Plan:
- req 25/5 tag 3, resp_ready=1 → exactly one div_start pulse; resp q=5, r=0, tag=3, err=00; op_count=1.
- req 5/0 → no div_start; resp_valid the cycle after accept; q=0, r=0, err=01.
- req 127/3 with resp_ready held 0 for 10 cycles → q=42, r=1 stable all 10 cycles; req_ready=0 throughout; one op_count increment after release.
- div_done forced low (stub divider), TIMEOUT=64 → resp err=10, q=r=0 reached 64 cycles after div_start; a following 54/7 then completes with q=7, r=5, err=00.
- Assert reset in WAIT during -128/7 → outputs at reset values immediately (async), no response emitted; a subsequent -25/-5 gives q=5, r=0.
- Back-to-back requests with req_valid held high → each accepted only in IDLE; op_count equals the number of responses.
